// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Program-load engine. It takes structured instruction descriptors (a mnemonic
// class plus register, immediate and jump-target fields) and turns each one into
// a 32-bit MIPS instruction word. The words are written into instruction memory
// at consecutive word addresses, starting at BASE_ADDR. The opcode, funct and
// field layout match the ID-stage decoder, so every word written decodes back
// to the descriptor that produced it.
//
// Parameters
//   DWIDTH    : instruction word width (only 32 is meaningful)
//   AWIDTH    : imem word-address width
//   BASE_ADDR : first word address written after start
//
// Ports
//   clk, rstn          : clock, synchronous active-low reset
//   start              : one-cycle pulse that opens a session (IDLE/DONE only)
//   in_valid/in_ready  : descriptor handshake
//   in_kind .. in_last : descriptor fields
//   imem_we/imem_wready: write handshake toward imem
//   imem_waddr/wdata   : write address and encoded word
//   busy, done, err    : status (err is sticky: illegal kind or overflow)
//   count              : words whose write completed this session
//   dbg_state          : current FSM state (0 IDLE, 1 LOAD, 2 DRAIN, 3 DONE)
//
// Handshake semantics (both interfaces): a transfer happens on a rising edge
// where valid and ready are both high. Once the output register raises
// imem_we, it holds imem_we/imem_waddr/imem_wdata unchanged until imem_wready
// is seen. Readiness never depends on the same-cycle valid from the producer
// of that transfer.
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_addr,
    input  logic              in_last,
    output logic              imem_we,
    input  logic              imem_wready,
    output logic [AWIDTH-1:0] imem_waddr,
    output logic [DWIDTH-1:0] imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AWIDTH:0]   count,
    output logic [1:0]        dbg_state
);

    // Descriptor kinds
    localparam logic [3:0] K_ADD  = 4'd0;
    localparam logic [3:0] K_SUB  = 4'd1;
    localparam logic [3:0] K_AND  = 4'd2;
    localparam logic [3:0] K_OR   = 4'd3;
    localparam logic [3:0] K_NOR  = 4'd4;
    localparam logic [3:0] K_SLT  = 4'd5;
    localparam logic [3:0] K_JR   = 4'd6;
    localparam logic [3:0] K_ADDI = 4'd7;
    localparam logic [3:0] K_SLTI = 4'd8;
    localparam logic [3:0] K_LW   = 4'd9;
    localparam logic [3:0] K_SW   = 4'd10;
    localparam logic [3:0] K_BEQ  = 4'd11;
    localparam logic [3:0] K_J    = 4'd12;
    localparam logic [3:0] K_JAL  = 4'd13;
    localparam logic [3:0] K_NOP  = 4'd14;
    localparam logic [3:0] K_ILL  = 4'd15;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [AWIDTH-1:0] BASE     = AWIDTH'(BASE_ADDR);
    localparam logic [AWIDTH-1:0] TOP_ADDR = {AWIDTH{1'b1}};
    localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_we;
    logic [AWIDTH-1:0]   r_waddr;
    logic [DWIDTH-1:0]   r_wdata;
    logic [AWIDTH-1:0]   r_wptr;
    logic [AWIDTH:0]     r_count;
    logic                r_err;

    logic [31:0]         w_enc;
    logic                w_legal;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_wdone;

    // -------------------------------------------------------------------------
    // Encoder: pure combinational map from descriptor to instruction word.
    // Fields a kind does not use are simply not wired into its word.
    // -------------------------------------------------------------------------
    always_comb begin
        w_enc   = 32'h0000_0000;
        w_legal = 1'b1;
        case (in_kind)
            K_ADD:  w_enc = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_ADD};
            K_SUB:  w_enc = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SUB};
            K_AND:  w_enc = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_AND};
            K_OR:   w_enc = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_OR};
            K_NOR:  w_enc = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_NOR};
            K_SLT:  w_enc = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SLT};
            K_JR:   w_enc = {OP_RTYPE, in_rs, 15'b0, FN_JR};
            K_ADDI: w_enc = {OP_ADDI, in_rs, in_rt, in_imm};
            K_SLTI: w_enc = {OP_SLTI, in_rs, in_rt, in_imm};
            K_LW:   w_enc = {OP_LW, in_rs, in_rt, in_imm};
            K_SW:   w_enc = {OP_SW, in_rs, in_rt, in_imm};
            K_BEQ:  w_enc = {OP_BEQ, in_rs, in_rt, in_imm};
            K_J:    w_enc = {OP_J, in_addr};
            K_JAL:  w_enc = {OP_JAL, in_addr};
            K_NOP:  w_enc = 32'h0000_0000;
            K_ILL:  w_legal = 1'b0;
            default: w_legal = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Handshakes. The single output register can take a new word whenever it
    // is empty or is being emptied this same edge, which gives one word per
    // cycle with imem_wready high and no bubble on release of backpressure.
    // -------------------------------------------------------------------------
    assign w_wdone    = r_we && imem_wready;
    assign w_in_ready = (r_state == ST_LOAD) && (!r_we || imem_wready);
    assign w_accept   = in_valid && w_in_ready;

    // -------------------------------------------------------------------------
    // FSM and output register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_waddr <= BASE;
            r_wdata <= '0;
            r_wptr  <= BASE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            // count tracks completed writes, which can finish in LOAD or DRAIN
            if (w_wdone) begin
                r_count <= r_count + CNT_ONE;
            end

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_wptr  <= BASE;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end

                ST_LOAD: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_we    <= 1'b1;
                            r_waddr <= r_wptr;
                            r_wdata <= w_enc;
                            r_wptr  <= r_wptr + 1'b1;
                            // Writing the last address ends the session; it is
                            // flagged as overflow even if in_last is also set.
                            if (r_wptr == TOP_ADDR) begin
                                r_err   <= 1'b1;
                                r_state <= ST_DRAIN;
                            end else if (in_last) begin
                                r_state <= ST_DRAIN;
                            end
                        end else begin
                            // Illegal kind: consume and drop. Any pending
                            // write is necessarily completing this edge.
                            r_err <= 1'b1;
                            if (w_wdone) begin
                                r_we <= 1'b0;
                            end
                            if (in_last) begin
                                r_state <= ST_DRAIN;
                            end
                        end
                    end else if (w_wdone) begin
                        r_we <= 1'b0;
                    end
                end

                ST_DRAIN: begin
                    if (!r_we || imem_wready) begin
                        r_we    <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready   = w_in_ready;
    assign imem_we    = r_we;
    assign imem_waddr = r_waddr;
    assign imem_wdata = r_wdata;
    assign busy       = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
    assign done       = (r_state == ST_DONE);
    assign err        = r_err;
    assign count      = r_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed bench for instr_encoder. Instance u_dut uses the default geometry
// (AWIDTH = 10, BASE_ADDR = 0); instance u_small uses AWIDTH = 2 so the
// address-overflow path can be reached in a handful of words. Expected words
// are hand-encoded constants.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam logic [3:0] K_ADD  = 4'd0;
    localparam logic [3:0] K_SUB  = 4'd1;
    localparam logic [3:0] K_OR   = 4'd3;
    localparam logic [3:0] K_SLT  = 4'd5;
    localparam logic [3:0] K_JR   = 4'd6;
    localparam logic [3:0] K_ADDI = 4'd7;
    localparam logic [3:0] K_LW   = 4'd9;
    localparam logic [3:0] K_SW   = 4'd10;
    localparam logic [3:0] K_BEQ  = 4'd11;
    localparam logic [3:0] K_J    = 4'd12;
    localparam logic [3:0] K_JAL  = 4'd13;
    localparam logic [3:0] K_NOP  = 4'd14;
    localparam logic [3:0] K_ILL  = 4'd15;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rstn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared descriptor fields ----------------
    logic [3:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_addr;
    logic        in_last;

    // ---------------- main instance signals ----------------
    logic        start, in_valid, in_ready;
    logic        imem_we, imem_wready;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        busy, done, err;
    logic [10:0] count;
    logic [1:0]  dbg_state;

    // ---------------- small instance signals ----------------
    logic        b_start, b_in_valid, b_in_ready;
    logic        b_we, b_wready;
    logic [1:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        b_busy, b_done, b_err;
    logic [2:0]  b_count;
    logic [1:0]  b_dbg_state;

    instr_encoder #(.DWIDTH(32), .AWIDTH(10), .BASE_ADDR(0)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_addr    (in_addr),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_wready(imem_wready),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .count      (count),
        .dbg_state  (dbg_state)
    );

    instr_encoder #(.DWIDTH(32), .AWIDTH(2), .BASE_ADDR(0)) u_small (
        .clk        (clk),
        .rstn       (rstn),
        .start      (b_start),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_addr    (in_addr),
        .in_last    (in_last),
        .imem_we    (b_we),
        .imem_wready(b_wready),
        .imem_waddr (b_waddr),
        .imem_wdata (b_wdata),
        .busy       (b_busy),
        .done       (b_done),
        .err        (b_err),
        .count      (b_count),
        .dbg_state  (b_dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [15:0] imm,
                            input logic [25:0] addr, input logic last);
        in_kind = k;
        in_rs   = rs;
        in_rt   = rt;
        in_rd   = rd;
        in_imm  = imm;
        in_addr = addr;
        in_last = last;
    endtask

    task automatic check_write(input string tag, input logic [9:0] a, input logic [31:0] d);
        check({tag, "_we"},   64'(imem_we),    64'd1);
        check({tag, "_addr"}, 64'(imem_waddr), 64'(a));
        check({tag, "_data"}, 64'(imem_wdata), 64'(d));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rstn        = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        imem_wready = 1'b1;
        b_start     = 1'b0;
        b_in_valid  = 1'b0;
        b_wready    = 1'b1;
        set_desc(K_NOP, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);

        // ---- reset values ----
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready),   64'd0);
        check("rst_we",       64'(imem_we),    64'd0);
        check("rst_waddr",    64'(imem_waddr), 64'd0);
        check("rst_wdata",    64'(imem_wdata), 64'd0);
        check("rst_busy",     64'(busy),       64'd0);
        check("rst_done",     64'(done),       64'd0);
        check("rst_err",      64'(err),        64'd0);
        check("rst_count",    64'(count),      64'd0);
        check("rst_state",    64'(dbg_state),  64'd0);
        check("rst_b_state",  64'(b_dbg_state),64'd0);
        rstn = 1'b1;
        tick();

        // ---- session 1: five words, back-to-back ----
        pulse_start();
        check("s1_state",    64'(dbg_state), 64'd1);
        check("s1_busy",     64'(busy),      64'd1);
        check("s1_in_ready", 64'(in_ready),  64'd1);

        in_valid = 1'b1;
        set_desc(K_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        tick();
        check_write("s1_add", 10'd0, 32'h0022_1820);
        check("s1_cnt0", 64'(count), 64'd0);

        set_desc(K_ADDI, 5'd0, 5'd8, 5'd0, 16'd5, 26'h0, 1'b0);
        tick();
        check_write("s1_addi", 10'd1, 32'h2008_0005);
        check("s1_cnt1", 64'(count), 64'd1);

        set_desc(K_LW, 5'd29, 5'd9, 5'd0, 16'hFFFC, 26'h0, 1'b0);
        tick();
        check_write("s1_lw", 10'd2, 32'h8FA9_FFFC);
        check("s1_cnt2", 64'(count), 64'd2);

        set_desc(K_SW, 5'd29, 5'd9, 5'd0, 16'd4, 26'h0, 1'b0);
        tick();
        check_write("s1_sw", 10'd3, 32'hAFA9_0004);

        set_desc(K_BEQ, 5'd1, 5'd2, 5'd0, 16'd3, 26'h0, 1'b1);
        tick();
        check_write("s1_beq", 10'd4, 32'h1022_0003);
        check("s1_drain_state", 64'(dbg_state), 64'd2);
        check("s1_drain_rdy",   64'(in_ready),  64'd0);

        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        check("s1_done",  64'(done),      64'd1);
        check("s1_count", 64'(count),     64'd5);
        check("s1_err",   64'(err),       64'd0);
        check("s1_we",    64'(imem_we),   64'd0);
        check("s1_busy",  64'(busy),      64'd0);
        check("s1_state", 64'(dbg_state), 64'd3);

        // ---- session 2: JR / J / JAL / NOP, start while busy ignored ----
        pulse_start();
        in_valid = 1'b1;
        set_desc(K_JR, 5'd31, 5'd4, 5'd5, 16'h1234, 26'h55, 1'b0);
        tick();
        check_write("s2_jr", 10'd0, 32'h03E0_0008);

        set_desc(K_J, 5'd3, 5'd3, 5'd3, 16'hFFFF, 26'h10, 1'b0);
        tick();
        check_write("s2_j", 10'd1, 32'h0800_0010);

        set_desc(K_JAL, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_write("s2_jal", 10'd2, 32'h0C00_0100);
        check("s2_busy_start_state", 64'(dbg_state), 64'd1);
        check("s2_busy_start_cnt",   64'(count),     64'd2);

        set_desc(K_NOP, 5'd7, 5'd9, 5'd3, 16'hABCD, 26'h3FF_FFFF, 1'b1);
        tick();
        check_write("s2_nop", 10'd3, 32'h0000_0000);

        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        check("s2_done",  64'(done),  64'd1);
        check("s2_count", 64'(count), 64'd4);

        // ---- session 3: illegal kind between two legal words ----
        pulse_start();
        in_valid = 1'b1;
        set_desc(K_OR, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0);
        tick();
        check_write("s3_or", 10'd0, 32'h0085_3025);

        set_desc(K_ILL, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0);
        tick();
        check("s3_ill_err",   64'(err),       64'd1);
        check("s3_ill_we",    64'(imem_we),   64'd0);
        check("s3_ill_cnt",   64'(count),     64'd1);
        check("s3_ill_state", 64'(dbg_state), 64'd1);

        set_desc(K_SLT, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b1);
        tick();
        check_write("s3_slt", 10'd1, 32'h00E8_482A);

        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        check("s3_done",  64'(done),  64'd1);
        check("s3_count", 64'(count), 64'd2);
        check("s3_err",   64'(err),   64'd1);

        // ---- session 4: backpressure ----
        pulse_start();
        check("s4_err_clr", 64'(err), 64'd0);
        imem_wready = 1'b0;
        in_valid    = 1'b1;
        set_desc(K_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        tick();
        check_write("s4_a", 10'd0, 32'h0022_1820);

        set_desc(K_SUB, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
        #1;
        check("s4_stall_rdy0", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_write($sformatf("s4_hold%0d", i), 10'd0, 32'h0022_1820);
            check($sformatf("s4_hold%0d_rdy", i), 64'(in_ready), 64'd0);
            check($sformatf("s4_hold%0d_cnt", i), 64'(count),    64'd0);
        end

        imem_wready = 1'b1;
        #1;
        check("s4_release_rdy", 64'(in_ready), 64'd1);
        tick();
        check_write("s4_b", 10'd1, 32'h0022_1822);
        check("s4_b_cnt",   64'(count),     64'd1);
        check("s4_b_state", 64'(dbg_state), 64'd2);

        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        check("s4_done",  64'(done),  64'd1);
        check("s4_count", 64'(count), 64'd2);

        // ---- session 5: reset with a write pending ----
        pulse_start();
        imem_wready = 1'b0;
        in_valid    = 1'b1;
        set_desc(K_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        tick();
        check_write("s5_pend", 10'd0, 32'h0022_1820);

        in_valid = 1'b0;
        rstn     = 1'b0;
        tick();
        check("s5_rst_we",    64'(imem_we),    64'd0);
        check("s5_rst_cnt",   64'(count),      64'd0);
        check("s5_rst_state", 64'(dbg_state),  64'd0);
        check("s5_rst_waddr", 64'(imem_waddr), 64'd0);
        check("s5_rst_wdata", 64'(imem_wdata), 64'd0);
        check("s5_rst_busy",  64'(busy),       64'd0);

        rstn        = 1'b1;
        imem_wready = 1'b1;
        pulse_start();
        check("s5_restart_state", 64'(dbg_state), 64'd1);
        in_valid = 1'b1;
        set_desc(K_SUB, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
        tick();
        check_write("s5_sub", 10'd0, 32'h0022_1822);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        check("s5_done",  64'(done),  64'd1);
        check("s5_count", 64'(count), 64'd1);

        // ---- small instance: address-space overflow ----
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_desc(K_ADDI, 5'd0, 5'd8, 5'd0, 16'(i), 26'h0, 1'b0);
            tick();
            check($sformatf("ov_we%0d", i),   64'(b_we),    64'd1);
            check($sformatf("ov_addr%0d", i), 64'(b_waddr), 64'(i));
            check($sformatf("ov_data%0d", i), 64'(b_wdata), 64'(32'h2008_0000 | 32'(i)));
            check($sformatf("ov_cnt%0d", i),  64'(b_count), 64'(i));
        end
        check("ov_err",   64'(b_err),       64'd1);
        check("ov_state", 64'(b_dbg_state), 64'd2);
        check("ov_rdy",   64'(b_in_ready),  64'd0);

        // fifth descriptor stays offered but must never be taken
        set_desc(K_ADDI, 5'd0, 5'd8, 5'd0, 16'd4, 26'h0, 1'b0);
        tick();
        check("ov_done",  64'(b_done),     64'd1);
        check("ov_count", 64'(b_count),    64'd4);
        check("ov_we",    64'(b_we),       64'd0);
        check("ov_rdy2",  64'(b_in_ready), 64'd0);
        tick();
        check("ov_count2", 64'(b_count), 64'd4);
        check("ov_we2",    64'(b_we),    64'd0);
        check("ov_err2",   64'(b_err),   64'd1);
        b_in_valid = 1'b0;

        // ---- final report ----
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-load engine that turns structured instruction descriptors (mnemonic class plus register/immediate/target fields) into 32-bit MIPS instruction words and streams them into instruction memory at consecutive word addresses. It is the inverse of the pipeline's ID-stage decoder and uses the same opcode, funct and field layout. It sits between the boot/test host interface and the imem write port. Words it writes must decode back to the fields that produced them.

## Interface
- DWIDTH, 32: instruction word width; only 32 is supported.
- AWIDTH, 10: imem word-address width.
- BASE_ADDR, 0: first word address written after `start`.

- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load session; honoured only in IDLE or DONE.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when `in_valid && in_ready`.
- in_kind  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 SLT, 6 JR, 7 ADDI, 8 SLTI, 9 LW, 10 SW, 11 BEQ, 12 J, 13 JAL, 14 NOP, 15 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  I-type immediate, passed through raw.
- in_addr  in  26  J/JAL target field.
- in_last  in  1  marks the final descriptor of the session.
- imem_we  out  1  write strobe (out-valid).
- imem_wready  in  1  the write completes when `imem_we && imem_wready`.
- imem_waddr  out  AWIDTH  word address.
- imem_wdata  out  DWIDTH  encoded instruction.
- busy  out  1  state is LOAD or DRAIN.
- done  out  1  state is DONE.
- err  out  1  sticky flag: an illegal kind was seen or the address space overflowed.
- count  out  AWIDTH+1  words written this session.

## Operation
States:
- IDLE: `in_ready` = 0. On `start`, load `wptr` with BASE_ADDR, clear `count` and `err`, go to LOAD.
- LOAD: `in_ready = !imem_we || imem_wready`, i.e. a single output register with pass-through on drain.
  - Legal accept: register the encoded word at `wptr`, assert `imem_we`, then `wptr` += 1.
  - Accept with `in_last` = 1, or accept of the word at address 2^AWIDTH−1: go to DRAIN. For the top-address case also set `err` (overflow).
- DRAIN: `in_ready` = 0. Go to DONE once the pending write completes.
- DONE: hold all outputs. `start` re-enters LOAD, with the same actions as from IDLE.

Illegal kind (15) in LOAD:
- The descriptor is accepted and dropped; nothing is written.
- `err` is set, `wptr` and `count` are unchanged.
- If `in_last` is set, go to DRAIN.

`start` while busy is ignored.

`count` increments on each completed write, not on each accept.

Encodings (op = opcode[31:26]):
- R-type (ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, NOR 0x27, SLT 0x2A): {6'h00, rs, rt, rd, 5'b0, funct}.
- JR: {6'h00, rs, 15'b0, 6'h08}.
- ADDI 0x08, SLTI 0x0A, LW 0x23, SW 0x2B, BEQ 0x04: {op, rs, rt, imm}.
- J 0x02, JAL 0x03: {op, addr}.
- NOP: 32'h0000_0000.
- Unused fields in the descriptor are ignored.

## Timing
- Reset values: state IDLE, `in_ready` 0, `imem_we` 0, `imem_waddr` BASE_ADDR, `imem_wdata` 0, `busy` 0, `done` 0, `err` 0, `count` 0.
- Latency: a descriptor accepted at edge N appears on `imem_*` from edge N, held until `imem_wready`.
- Throughput: 1 word/cycle with `imem_wready` tied high.
- Simultaneous write-complete and new accept in the same cycle: the output register reloads with no bubble.
- `imem_we`, `imem_waddr` and `imem_wdata` stay stable while `imem_we && !imem_wready`.
- `rstn` low mid-session: the next edge restores reset values and the pending write is abandoned.

## Test plan
- Reset, `start`, then stream 5 descriptors with `imem_wready` = 1 -> writes at 0..4, back-to-back:
  - ADD rs1 rt2 rd3 -> 0x00221820
  - ADDI rs0 rt8 imm5 -> 0x20080005
  - LW rs29 rt9 imm 0xFFFC -> 0x8FA9FFFC
  - SW rs29 rt9 imm4 -> 0xAFA90004
  - BEQ rs1 rt2 imm3 with `in_last` -> 0x10220003
  - Result: `count` = 5, `done` = 1, `err` = 0.
- JR rs31 -> 0x03E00008; J addr 0x10 -> 0x08000010; JAL addr 0x100 -> 0x0C000100; NOP -> 0x0.
- Backpressure: hold `imem_wready` = 0 for 3 cycles -> outputs stable, `in_ready` = 0; on release, the next word follows in the same cycle.
- Kind 15 between two legal words -> `err` = 1; legal words land at consecutive addresses; `count` = 2.
- AWIDTH = 2, 5 descriptors with no `in_last` -> 4 words written at 0..3, `err` = 1, DONE, 5th not accepted.
- `rstn` low while `imem_we` is pending -> IDLE next cycle, `imem_we` = 0, `count` = 0; `start` restarts at BASE_ADDR.
